// File: rtl/operand_loader_if.sv
// Board-side bundle for operand_loader: switch/button inputs plus the register load bus.
interface operand_loader_if;
  logic [7:0] sw;
  logic       enter;
  logic       clear;
  logic [7:0] data_out;
  logic       en_a;
  logic       en_b;
  logic       en_op;
  logic [1:0] stage;
  logic       ready;

  modport master (
    output sw, enter, clear,
    input  data_out, en_a, en_b, en_op, stage, ready
  );

  modport slave (
    input  sw, enter, clear,
    output data_out, en_a, en_b, en_op, stage, ready
  );
endinterface

// File: rtl/operand_loader.sv
// Samples the switches on each debounced enter press and strobes operand A, B and opcode loads in turn.
module operand_loader #(
  parameter int unsigned HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             rst,
  operand_loader_if.slave  bus
);

  localparam int unsigned CNT_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t           state;
  logic             sync_meta;
  logic             sync_now;
  logic             sync_prev;
  logic             edge_q;
  logic [CNT_W-1:0] holdoff_cnt;
  logic [7:0]       data_q;
  logic             en_a_q;
  logic             en_b_q;
  logic             en_op_q;
  logic             ready_q;
  logic             accept_c;

  // Two-flop synchronizer followed by a registered rising-edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_now  <= 1'b0;
      sync_prev <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      sync_meta <= bus.enter;
      sync_now  <= sync_meta;
      sync_prev <= sync_now;
      edge_q    <= sync_now & ~sync_prev;
    end
  end

  // Edges arriving during holdoff or alongside clear are dropped, not queued.
  assign accept_c = edge_q && (holdoff_cnt == '0) && !bus.clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LOAD_A;
      holdoff_cnt <= '0;
      data_q      <= 8'h00;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      en_op_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      en_op_q <= 1'b0;
      if (bus.clear) begin
        state       <= LOAD_A;
        holdoff_cnt <= '0;
        ready_q     <= 1'b0;
      end else if (accept_c) begin
        holdoff_cnt <= CNT_W'(HOLDOFF);
        data_q      <= bus.sw;
        case (state)
          LOAD_A: begin
            en_a_q  <= 1'b1;
            state   <= LOAD_B;
            ready_q <= 1'b0;
          end
          LOAD_B: begin
            en_b_q  <= 1'b1;
            state   <= LOAD_OP;
            ready_q <= 1'b0;
          end
          LOAD_OP: begin
            en_op_q <= 1'b1;
            state   <= READY;
            ready_q <= 1'b1;
          end
          READY: begin
            // A press from READY immediately starts the next operation with a new A.
            en_a_q  <= 1'b1;
            state   <= LOAD_B;
            ready_q <= 1'b0;
          end
          default: begin
            state   <= LOAD_A;
            ready_q <= 1'b0;
          end
        endcase
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.en_a     = en_a_q;
  assign bus.en_b     = en_b_q;
  assign bus.en_op    = en_op_q;
  assign bus.stage    = state;
  assign bus.ready    = ready_q;

endmodule

// File: doc/operand_loader.md
# operand_loader

Sequencing front end that drives the calculator's 8-bit operand registers. It samples the 8 input switches on each press of an enter button and emits one-cycle load strobes, in order, for operand A, operand B and the opcode, over a shared 8-bit data bus. It then flags that a complete operation is ready. It sits between the board I/O and the register file, on the write side of each register's enable/data port.

## Interface
- HOLDOFF, default 4: cycles after an accepted press during which further enter edges are ignored (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw  in  8  switch value; sampled in the cycle an enter edge is accepted.
- enter  in  1  raw asynchronous button level.
- clear  in  1  synchronous abort; returns to LOAD_A.
- data_out  out  8  registered load bus to register data inputs.
- en_a  out  1  one-cycle load strobe, operand A register.
- en_b  out  1  one-cycle load strobe, operand B register.
- en_op  out  1  one-cycle load strobe, opcode register (consumer uses low bits).
- stage  out  2  current state encoding: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 READY.
- ready  out  1  level, high while in READY.

## Operation
- enter passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized level. Edge = sync_now & ~sync_prev.
- An edge is accepted only when the holdoff counter is 0 and clear is low. Acceptance loads the counter with HOLDOFF, and it then decrements to 0, one per cycle. Edges seen while the counter is nonzero are discarded, not queued.
- On an accepted edge, data_out <= sw, and exactly one strobe is set for the next cycle, per state:
  - LOAD_A: en_a, then go to LOAD_B.
  - LOAD_B: en_b, then go to LOAD_OP.
  - LOAD_OP: en_op, then go to READY.
  - READY: en_a, then go to LOAD_B. A new A is loaded immediately and starts the next operation.
- Strobes are one-hot or all zero. Each is high for exactly one cycle.
- data_out holds its last value until the next accepted edge. It is never changed while a strobe is high.
- clear high in any state:
  - next state is LOAD_A;
  - all strobes are 0 next cycle;
  - the holdoff counter is zeroed;
  - data_out is unchanged.
- clear wins over a simultaneous edge, and that edge is lost.
- ready = (state == READY).

## Timing
- Reset values: data_out=0x00, en_a=en_b=en_op=0, stage=0 (LOAD_A), ready=0, synchronizer and edge flops 0, holdoff counter 0.
- Latency: enter rising before clk edge k gives a synchronized edge visible in cycle k+2. That cycle registers data_out and a strobe, both valid from edge k+3, so the strobe is high during cycle k+3.
- A register with a write enable captures data_out on the edge that ends the strobe cycle.
- The state transition is registered in the same edge as the strobe. stage and ready change together with the strobe.
- Minimum spacing of accepted presses is HOLDOFF+1 cycles.
- Reset asserted mid-operation immediately forces all reset values, including any strobe in flight. After release the first accepted press loads A.
- An enter level held high produces only one edge. A release followed by a re-press after holdoff produces a new edge.

## Test plan
- Reset, then press enter three times with sw=0x2A, 0x07, 0x01, each press more than HOLDOFF+3 cycles apart. Required: one strobe each, en_a, then en_b, then en_op, with data_out 0x2A, 0x07, 0x01 during the respective strobes. Each strobe arrives 3 cycles after the enter rise. stage ends at 3 and ready=1.
- From READY, press with sw=0x55. Required: en_a with data_out=0x55, stage=1, ready=0.
- Bounce with HOLDOFF=4: enter toggles 1,0,1,0,1 on successive cycles. Required: exactly one strobe. A clean press 10 cycles later produces the next strobe.
- In LOAD_OP, assert clear in the same cycle as a detected edge with sw=0xFF. Required: no strobe, stage=0, and data_out keeps its previous value.
- Assert rst asynchronously during the cycle en_b is high. Required: en_b drops immediately and all outputs take their reset values. The next press yields en_a.
- Hold enter high for 50 cycles, then release. Required: exactly one strobe.
